// File: rtl/n64_pkg.sv
// n64_pkg
//   Shared definitions for the N64 button event path: word widths, the
//   event field layout and a lowest-set-bit helper used by the scanner.
//   Event word layout: [4] = 1 press / 0 release, [3:0] = button index.
package n64_pkg;

  localparam int N64_BTN_W         = 16;
  localparam int N64_IDX_W         = 4;
  localparam int N64_EVT_W         = 5;
  localparam int N64_EVT_PRESS_BIT = 4;
  localparam int N64_EVT_IDX_LSB   = 0;
  localparam int N64_EVT_IDX_MSB   = 3;
  localparam int N64_CNT_W         = 4;
  localparam int N64_ERR_W         = 8;

  typedef struct packed {
    logic                 press;
    logic [N64_IDX_W-1:0] idx;
  } n64_evt_t;

  // Index of the lowest set bit; 0 when the vector is empty (callers gate
  // on a non-zero vector).
  function automatic logic [N64_IDX_W-1:0] n64_lowest_idx(input logic [N64_BTN_W-1:0] v);
    n64_lowest_idx = '0;
    for (int i = N64_BTN_W - 1; i >= 0; i--) begin
      if (v[i]) n64_lowest_idx = N64_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/n64_evt_fifo.sv
// n64_evt_fifo
//   Synchronous first-word-fall-through FIFO for button events.
//   Ports:
//     clk, rst       clock, synchronous active-high reset (empties the FIFO)
//     push, din      write request and data; ignored when full unless a pop
//                    happens in the same cycle
//     full           no free entry
//     pop            read request; ignored when empty
//     dout           head entry, valid whenever empty = 0
//     empty          no entry stored
//     count          occupancy 0..DEPTH
module n64_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = n64_pkg::N64_EVT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // A push while full is accepted only when the head leaves in the same
  // cycle. A push into an empty FIFO becomes visible the following cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/n64_button_events.sv
// n64_button_events
//   Debounces raw N64 controller frames and turns every accepted change of
//   button state into press/release events queued in a FWFT FIFO.
//   Ports:
//     clk, rst                     fabric clock, synchronous active-high reset
//     frame_valid/_error/_data     frame strobe from the button reader
//     buttons_stable               debounced button state
//     evt_valid, evt_data,
//     evt_ready                    event stream, head moves when valid & ready
//     err_count                    saturating count of corrupt frames
//     LED                          [3:0] FIFO occupancy (sat. 15), [4] any button held
//   Handshake: an event transfers on a clk edge where evt_valid and
//   evt_ready are both 1; evt_data holds while evt_valid=1 and evt_ready=0.
module n64_button_events
  import n64_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_valid,
  input  logic                 frame_error,
  input  logic [N64_BTN_W-1:0] frame_data,
  output logic [N64_BTN_W-1:0] buttons_stable,
  output logic                 evt_valid,
  output logic [N64_EVT_W-1:0] evt_data,
  input  logic                 evt_ready,
  output logic [N64_ERR_W-1:0] err_count,
  output logic [4:0]           LED
);

  localparam logic [N64_CNT_W-1:0] DEB_TH  = N64_CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [N64_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [N64_ERR_W-1:0] ERR_MAX = '1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  logic [N64_BTN_W-1:0] candidate_q, candidate_d;
  logic [N64_CNT_W-1:0] count_q, count_d;
  logic [N64_BTN_W-1:0] stable_q, stable_d;
  logic [N64_BTN_W-1:0] pending_q, pending_d;
  logic [N64_BTN_W-1:0] snapshot_q, snapshot_d;
  logic [N64_ERR_W-1:0] err_q, err_d;

  logic                 good_frame, bad_frame, commit;
  logic                 fifo_full, fifo_empty, fifo_pop, can_accept, scan_push;
  logic [N64_IDX_W-1:0] scan_idx;
  n64_evt_t             scan_evt;
  logic [N64_EVT_W-1:0] fifo_dout;
  logic [FCW-1:0]       fifo_count;
  logic [3:0]           led_occ;

  assign good_frame = frame_valid && !frame_error;
  assign bad_frame  = frame_valid && frame_error;
  assign fifo_pop   = !fifo_empty && evt_ready;
  // A full FIFO still takes a push when its head leaves this cycle.
  assign can_accept = !fifo_full || fifo_pop;
  assign scan_idx   = n64_lowest_idx(pending_q);
  assign scan_push  = (pending_q != '0) && can_accept;
  // A new state is committed only once the previous change set is fully
  // queued, so snapshot and pending always describe one commit.
  assign commit     = (count_q >= DEB_TH) && (candidate_q != stable_q) && (pending_q == '0);

  always_comb begin
    scan_evt.press = snapshot_q[scan_idx];
    scan_evt.idx   = scan_idx;
  end

  always_comb begin
    candidate_d = candidate_q;
    count_d     = count_q;
    stable_d    = stable_q;
    pending_d   = pending_q;
    snapshot_d  = snapshot_q;
    err_d       = err_q;

    if (good_frame) begin
      if (frame_data == candidate_q) begin
        count_d = (count_q == CNT_MAX) ? CNT_MAX : count_q + N64_CNT_W'(1);
      end else begin
        candidate_d = frame_data;
        count_d     = N64_CNT_W'(1);
      end
    end else if (bad_frame) begin
      count_d = '0;
      err_d   = (err_q == ERR_MAX) ? ERR_MAX : err_q + N64_ERR_W'(1);
    end

    // commit requires pending == 0, so it never coincides with a scan step.
    if (commit) begin
      stable_d   = candidate_q;
      pending_d  = stable_q ^ candidate_q;
      snapshot_d = candidate_q;
    end else if (scan_push) begin
      pending_d = pending_q & ~(N64_BTN_W'(1) << scan_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      candidate_q <= '0;
      count_q     <= '0;
      stable_q    <= '0;
      pending_q   <= '0;
      snapshot_q  <= '0;
      err_q       <= '0;
    end else begin
      candidate_q <= candidate_d;
      count_q     <= count_d;
      stable_q    <= stable_d;
      pending_q   <= pending_d;
      snapshot_q  <= snapshot_d;
      err_q       <= err_d;
    end
  end

  n64_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (N64_EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (scan_push),
    .din   (scan_evt),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    if (int'(fifo_count) > 15) led_occ = 4'd15;
    else                       led_occ = 4'(fifo_count);
  end

  assign buttons_stable = stable_q;
  assign evt_valid      = !fifo_empty;
  assign evt_data       = fifo_dout;
  assign err_count      = err_q;
  assign LED            = {|stable_q, led_occ};

endmodule

// File: tb/tb_n64_button_events.sv
// tb_n64_button_events
//   Directed scenarios plus a short random section for n64_button_events.
//   Expected events are queued when a committing frame is driven and
//   compared in order as the DUT hands them over.
module tb_n64_button_events;
  import n64_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_valid;
  logic        frame_error;
  logic [15:0] frame_data;
  logic [15:0] buttons_stable;
  logic        evt_valid;
  logic [4:0]  evt_data;
  logic        evt_ready;
  logic [7:0]  err_count;
  logic [4:0]  led;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [4:0]  exp_q[$];
  logic [4:0]  exp_e;
  logic [15:0] model_stable;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  n64_button_events #(
    .DEBOUNCE_FRAMES (2),
    .FIFO_DEPTH      (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_valid    (frame_valid),
    .frame_error    (frame_error),
    .frame_data     (frame_data),
    .buttons_stable (buttons_stable),
    .evt_valid      (evt_valid),
    .evt_data       (evt_data),
    .evt_ready      (evt_ready),
    .err_count      (err_count),
    .LED            (led)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [15:0] d, input logic err);
    frame_valid = 1'b1;
    frame_error = err;
    frame_data  = d;
    tick(1);
    frame_valid = 1'b0;
    frame_error = 1'b0;
  endtask

  task automatic do_reset();
    evt_ready = 1'b0;
    rst       = 1'b1;
    tick(1);
    rst       = 1'b0;
    exp_q.delete();
    model_stable = '0;
  endtask

  // Queue the events an accepted change from model_stable to nv must produce,
  // lowest button index first.
  task automatic expect_commit(input logic [15:0] nv);
    logic [15:0] diff;
    diff = model_stable ^ nv;
    for (int i = 0; i < 16; i++) begin
      if (diff[i]) exp_q.push_back({nv[i], 4'(i)});
    end
    model_stable = nv;
  endtask

  task automatic wait_drain(input bit rand_ready);
    int k;
    k = 0;
    if (!rand_ready) evt_ready = 1'b1;
    while ((exp_q.size() != 0 || evt_valid) && k < 400) begin
      if (rand_ready) evt_ready = 1'($urandom_range(0, 1));
      tick(1);
      k++;
    end
    evt_ready = 1'b1;
    check("drain_left", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        check("evt_unexpected", 32'(evt_data), 32'hDEAD);
      end else begin
        exp_e = exp_q.pop_front();
        check("evt_data", 32'(evt_data), 32'(exp_e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] v;
    rst          = 1'b1;
    frame_valid  = 1'b0;
    frame_error  = 1'b0;
    frame_data   = '0;
    evt_ready    = 1'b0;
    model_stable = '0;
    tick(2);
    rst = 1'b0;

    // Reset state
    check("rst_stable", 32'(buttons_stable), 0);
    check("rst_evt_valid", 32'(evt_valid), 0);
    check("rst_led", 32'(led), 0);
    check("rst_err", 32'(err_count), 0);

    // Two frames of 0x0001: exact latency
    send_frame(16'h0001, 1'b0);
    send_frame(16'h0001, 1'b0);
    expect_commit(16'h0001);
    check("lat_t1_stable", 32'(buttons_stable), 0);
    tick(1);
    check("lat_t2_stable", 32'(buttons_stable), 32'h0001);
    check("lat_t2_evt_valid", 32'(evt_valid), 0);
    tick(1);
    check("lat_t3_evt_valid", 32'(evt_valid), 1);
    check("lat_t3_evt_data", 32'(evt_data), 32'h10);
    check("lat_t3_led", 32'(led), 32'b10001);
    wait_drain(1'b0);
    check("lat_led_after", 32'(led), 32'b10000);

    // 0x0001, 0x0003, 0x0003: only the last state commits
    do_reset();
    evt_ready = 1'b1;
    send_frame(16'h0001, 1'b0);
    send_frame(16'h0003, 1'b0);
    check("nocommit_stable", 32'(buttons_stable), 0);
    send_frame(16'h0003, 1'b0);
    expect_commit(16'h0003);
    tick(1);
    check("seq_t2_stable", 32'(buttons_stable), 32'h0003);
    tick(1);
    check("seq_t3_evt", 32'(evt_data), 32'h10);
    tick(1);
    check("seq_t4_evt_valid", 32'(evt_valid), 1);
    check("seq_t4_evt", 32'(evt_data), 32'h11);
    wait_drain(1'b0);

    // Releases of 0x8001 held in the FIFO with evt_ready low
    do_reset();
    evt_ready = 1'b1;
    send_frame(16'h8001, 1'b0);
    send_frame(16'h8001, 1'b0);
    expect_commit(16'h8001);
    wait_drain(1'b0);
    check("rel_stable", 32'(buttons_stable), 32'h8001);
    evt_ready = 1'b0;
    send_frame(16'h0000, 1'b0);
    send_frame(16'h0000, 1'b0);
    expect_commit(16'h0000);
    tick(4);
    check("rel_led", 32'(led), 32'b00010);
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", 32'(evt_valid), 1);
      check("hold_data", 32'(evt_data), 32'h00);
      tick(1);
    end
    wait_drain(1'b0);

    // Error frame breaks agreement; 16 events stall at FIFO depth
    do_reset();
    send_frame(16'hFFFF, 1'b0);
    send_frame(16'h0000, 1'b1);
    send_frame(16'hFFFF, 1'b0);
    tick(4);
    check("err_nocommit", 32'(buttons_stable), 0);
    check("err_count1", 32'(err_count), 1);
    check("err_no_evt", 32'(evt_valid), 0);
    send_frame(16'hFFFF, 1'b0);
    expect_commit(16'hFFFF);
    tick(20);
    check("full_stable", 32'(buttons_stable), 32'hFFFF);
    check("full_led", 32'(led), 32'b11000);
    wait_drain(1'b0);
    check("full_led_after", 32'(led), 32'b10000);

    // Reset mid-scan, with a frame in the reset cycle
    do_reset();
    send_frame(16'h00F0, 1'b0);
    send_frame(16'h00F0, 1'b0);
    tick(4);
    check("midscan_led", 32'(led), 32'b10011);
    rst         = 1'b1;
    frame_valid = 1'b1;
    frame_data  = 16'h0002;
    tick(1);
    rst          = 1'b0;
    frame_valid  = 1'b0;
    exp_q.delete();
    model_stable = '0;
    check("post_rst_valid", 32'(evt_valid), 0);
    check("post_rst_stable", 32'(buttons_stable), 0);
    check("post_rst_led", 32'(led), 0);
    evt_ready = 1'b1;
    tick(10);
    check("post_rst_no_evt", 32'(evt_valid), 0);
    send_frame(16'h0002, 1'b0);
    tick(3);
    check("rst_frame_ignored", 32'(buttons_stable), 0);
    send_frame(16'h0002, 1'b0);
    expect_commit(16'h0002);
    wait_drain(1'b0);
    check("post_rst_commit", 32'(buttons_stable), 32'h0002);

    // err_count saturation
    do_reset();
    frame_valid = 1'b1;
    frame_error = 1'b1;
    frame_data  = 16'h1234;
    tick(300);
    check("err_sat", 32'(err_count), 255);
    tick(5);
    check("err_sat_hold", 32'(err_count), 255);
    frame_valid = 1'b0;
    frame_error = 1'b0;
    check("err_sat_stable", 32'(buttons_stable), 0);

    // Random button words with random consumer back-pressure
    for (int n = 0; n < 8; n++) begin
      v = 16'($urandom_range(0, 16'hFFFF));
      send_frame(v, 1'b0);
      send_frame(v, 1'b0);
      expect_commit(v);
      wait_drain(1'b1);
      check("rand_stable", 32'(buttons_stable), 32'(v));
      check("rand_led_bit4", 32'(led[4]), 32'(|v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/n64_button_events.md
N64_BUTTON_EVENTS -- requirements
Module: n64_button_events

Interface
REQ-001 SHALL provide parameter DEBOUNCE_FRAMES, default 2, legal 1..15: identical consecutive good frames required before a new button state is accepted.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 8, power of two: depth of the event queue.
REQ-003 SHALL have port clk  input  1  sole clock, the fabric clock that also drives the button reader.
REQ-004 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-005 SHALL have port frame_valid  input  1  single-cycle strobe; frame_data is valid this cycle.
REQ-006 SHALL have port frame_error  input  1  qualifies frame_valid; 1 marks the frame corrupt.
REQ-007 SHALL have port frame_data  input  16  raw button word from the reader; 1 means pressed.
REQ-008 SHALL have port buttons_stable  output  16  debounced button state.
REQ-009 SHALL have port evt_valid  output  1  event queue head is valid.
REQ-010 SHALL have port evt_data  output  5  bit [4]: 1 means press, 0 means release; bits [3:0]: button index 0..15.
REQ-011 SHALL have port evt_ready  input  1  consumer accepts the head when evt_valid and evt_ready are both 1.
REQ-012 SHALL have port err_count  output  8  saturating count of frames with frame_error=1.
REQ-013 SHALL have port LED  output  5  bits [3:0]: FIFO occupancy, saturated at 15; bit [4]: OR of buttons_stable.

Function
REQ-014 The block SHALL ignore any frame with frame_valid=1 and frame_error=1 for debounce purposes, clear the agreement count to 0, and increment err_count, saturating at 255.
REQ-015 On a good frame: if frame_data equals candidate, count SHALL increment, saturating at 15; otherwise candidate SHALL load frame_data and count SHALL load 1.
REQ-016 Commit SHALL occur in a cycle when count >= DEBOUNCE_FRAMES, candidate != buttons_stable, and pending == 0.
REQ-017 Commit effects: buttons_stable <= candidate; pending <= old buttons_stable XOR candidate; snapshot <= candidate.
REQ-018 While pending != 0, commit SHALL be blocked; count keeps saturating, and commit happens on the first cycle after pending clears if the conditions of REQ-016 still hold.
REQ-019 Event scanner: each cycle that pending != 0 and the FIFO can accept, the block SHALL push {snapshot[i], i} for the lowest set bit i of pending, then clear pending[i]; at most one push per cycle.
REQ-020 Latency: good frame at cycle T → candidate and count registered at T+1 → commit at the end of T+1 → first push during T+2 → evt_valid=1 at T+3. The scanner pushes K changed bits in K consecutive cycles if the FIFO is not full.
REQ-021 FIFO: first-word fall-through. Full with no pop SHALL stall the scanner, and no event is ever dropped. A push and a pop in the same cycle while full SHALL both occur, leaving occupancy unchanged. A pop and a push in the same cycle while empty SHALL NOT present the new entry until the next cycle.
REQ-022 evt_data SHALL hold steady while evt_valid=1 and evt_ready=0.
REQ-023 A frame arriving during a scan SHALL update candidate and count normally and SHALL NOT disturb pending or snapshot.

Reset
REQ-024 While rst=1 at a clk edge, the following SHALL be cleared: buttons_stable, candidate, snapshot, pending, count, err_count = 0; FIFO emptied; evt_valid = 0; LED = 0.
REQ-025 rst asserted mid-scan or mid-debounce SHALL discard all in-flight events; the first good frames after reset re-debounce from zero.
REQ-026 frame_valid seen in the same cycle as rst=1 SHALL be ignored.

Structure
REQ-027 Shared package n64_pkg SHALL hold N64_BTN_W=16, N64_IDX_W=4, N64_EVT_W=5, and the event field positions.
REQ-028 The FIFO SHALL be sub-module n64_evt_fifo (synchronous FWFT, parameter depth, ports clk/rst/push/din/full/pop/dout/empty/count); the debounce and scanner logic stay in n64_button_events.

Verification
REQ-029 Reset, then two good frames of 0x0001 → buttons_stable=0x0001 at T+2 of the second frame; one event 0x10 with evt_valid=1 at T+3; LED=5'b10001.
REQ-030 Frames 0x0001, 0x0003, 0x0003 → only 0x0003 commits; events 0x10, then 0x11 in consecutive cycles; no intermediate commit of 0x0001.
REQ-031 stable=0x8001, then two frames of 0x0000 with evt_ready=0 → FIFO holds 0x00 then 0x0F; holding evt_ready=0 keeps evt_data=0x00 steady.
REQ-032 Good 0xFFFF, frame_error frame, good 0xFFFF with DEBOUNCE_FRAMES=2 → no commit; err_count=1; a further 0xFFFF commits and 16 events are pushed, with the scanner stalling at 8 until evt_ready=1.
REQ-033 rst pulsed while pending=0x00F0 and the FIFO holds 3 entries → the cycle after reset: evt_valid=0, buttons_stable=0, LED=0, no stale events ever appear.
REQ-034 err_count driven with 300 error frames → err_count=255 and stays at 255.
